// File: rtl/el2_lsu_clken_pkg.sv
// rtl/el2_lsu_clken_pkg.sv - shared types and defaults for the LSU clock-enable controller
//
// Contents:
//   CLKEN_HOLD_W   default width of the per-channel hold counter
//   chan_state_e   per-channel enable FSM state (IDLE / ACTIVE / HOLD)
package el2_lsu_clken_pkg;

    localparam int unsigned CLKEN_HOLD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HOLD   = 2'd2
    } chan_state_e;

endpackage

// File: rtl/el2_lsu_clken_chan.sv
// rtl/el2_lsu_clken_chan.sv - one clock-enable channel: FSM, hold counter, tick qualify
//
// Ports:
//   clk, rst      core clock, asynchronous active-high reset
//   eff_req       effective request for this channel (already chained, already reset-gated)
//   hold_cfg      extra hold ticks after the request drops, sampled on ACTIVE exit
//   bus_clk_en    bus clock-ratio enable; only used when MASKED=1
//   force_on      clk_override | force_halt; forces the enable without touching state
//   chan_clken    clock enable for this channel's clock header
//   busy          FSM is not IDLE
module el2_lsu_clken_chan
    import el2_lsu_clken_pkg::*;
#(
    parameter int unsigned HOLD_W = CLKEN_HOLD_W,
    parameter bit          MASKED = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              eff_req,
    input  logic [HOLD_W-1:0] hold_cfg,
    input  logic              bus_clk_en,
    input  logic              force_on,
    output logic              chan_clken,
    output logic              busy
);

    chan_state_e       state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              tick;
    logic              raw;

    // Bus-qualified channels only advance on bus clock cycles, so both the
    // ACTIVE exit and every HOLD decrement wait for bus_clk_en.
    assign tick = MASKED ? bus_clk_en : 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (eff_req) begin
            // A request always wins, including on the last HOLD tick.
            state_d = ST_ACTIVE;
        end else begin
            case (state_q)
                ST_ACTIVE: begin
                    if (tick) begin
                        if (hold_cfg == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_HOLD;
                            cnt_d   = hold_cfg;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        cnt_d = cnt_q - 1'b1;
                        // <= 1 rather than == 1 so a corrupted zero count cannot wrap.
                        if (cnt_q <= 1) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign raw        = eff_req | busy | force_on;
    assign chan_clken = MASKED ? (raw & bus_clk_en) : raw;

endmodule

// File: rtl/el2_lsu_clken_ctrl.sv
// rtl/el2_lsu_clken_ctrl.sv - LSU clock-enable controller: chaining, per-channel FSMs, free enable, popcount
//
// Ports:
//   clk, rst       core clock, asynchronous active-high reset
//   clk_override   forces every enable high
//   force_halt     forces every enable high until the core halts
//   req            per-channel activity request
//   chain_en       bit i: channel i inherits channel i-1's request one cycle later (bit 0 unused)
//   hold_cfg       per-channel extra hold ticks, channel i at [i*HOLD_W +: HOLD_W]
//   bus_clk_en     bus clock-ratio enable for BUS_MASK channels
//   free_extra     extra free-clock activity (buffers non-empty)
//   chan_clken     per-channel clock enables
//   free_clken     free clock enable, stretched by one cycle
//   busy           any channel not IDLE
//   active_cnt     number of asserted chan_clken bits
module el2_lsu_clken_ctrl
    import el2_lsu_clken_pkg::*;
#(
    parameter int unsigned       NUM_CH   = 8,
    parameter int unsigned       HOLD_W   = CLKEN_HOLD_W,
    parameter logic [NUM_CH-1:0] BUS_MASK = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_override,
    input  logic                        force_halt,
    input  logic [NUM_CH-1:0]           req,
    input  logic [NUM_CH-1:0]           chain_en,
    input  logic [NUM_CH*HOLD_W-1:0]    hold_cfg,
    input  logic                        bus_clk_en,
    input  logic                        free_extra,
    output logic [NUM_CH-1:0]           chan_clken,
    output logic                        free_clken,
    output logic                        busy,
    output logic [$clog2(NUM_CH+1)-1:0] active_cnt
);

    localparam int unsigned CNT_W = $clog2(NUM_CH + 1);

    logic [NUM_CH-1:0] eff_req;
    logic [NUM_CH-1:0] eff_req_q;
    logic [NUM_CH-1:0] busy_vec;
    logic              force_on;
    logic              free_raw;
    logic              free_raw_q;
    logic              unused_chain0;

    assign force_on      = clk_override | force_halt;
    assign unused_chain0 = chain_en[0];

    // Chaining uses the registered request of the previous channel, so there
    // is never a combinational path longer than one channel. Requests are
    // masked during reset so only the overrides can raise enables then.
    always_comb begin
        eff_req = '0;
        if (!rst) begin
            eff_req[0] = req[0];
            for (int i = 1; i < NUM_CH; i++) begin
                eff_req[i] = req[i] | (chain_en[i] & eff_req_q[i-1]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eff_req_q  <= '0;
            free_raw_q <= 1'b0;
        end else begin
            eff_req_q  <= eff_req;
            free_raw_q <= free_raw;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        el2_lsu_clken_chan #(
            .HOLD_W (HOLD_W),
            .MASKED (BUS_MASK[g])
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .eff_req    (eff_req[g]),
            .hold_cfg   (hold_cfg[g*HOLD_W +: HOLD_W]),
            .bus_clk_en (bus_clk_en),
            .force_on   (force_on),
            .chan_clken (chan_clken[g]),
            .busy       (busy_vec[g])
        );
    end

    assign busy = |busy_vec;

    // free_extra is gated in reset so the free clock only follows the overrides there.
    assign free_raw   = (|eff_req) | busy | (free_extra & ~rst) | force_on;
    assign free_clken = free_raw | free_raw_q;

    always_comb begin
        active_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            active_cnt = active_cnt + CNT_W'(chan_clken[i]);
        end
    end

endmodule

// File: tb/tb_el2_lsu_clken_ctrl.sv
// tb/tb_el2_lsu_clken_ctrl.sv - self-checking bench for el2_lsu_clken_ctrl
module tb_el2_lsu_clken_ctrl;

    localparam int NUM_CH = 8;
    localparam int HOLD_W = 4;
    localparam int CNT_W  = $clog2(NUM_CH + 1);
    localparam logic [NUM_CH-1:0] BUS_MASK = 8'h24;
    localparam int BIG = 1000;

    logic                     clk;
    logic                     rst;
    logic                     clk_override;
    logic                     force_halt;
    logic [NUM_CH-1:0]        req;
    logic [NUM_CH-1:0]        chain_en;
    logic [NUM_CH*HOLD_W-1:0] hold_cfg;
    logic                     bus_clk_en;
    logic                     free_extra;
    logic [NUM_CH-1:0]        chan_clken;
    logic                     free_clken;
    logic                     busy;
    logic [CNT_W-1:0]         active_cnt;

    el2_lsu_clken_ctrl #(
        .NUM_CH   (NUM_CH),
        .HOLD_W   (HOLD_W),
        .BUS_MASK (BUS_MASK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clk_override (clk_override),
        .force_halt   (force_halt),
        .req          (req),
        .chain_en     (chain_en),
        .hold_cfg     (hold_cfg),
        .bus_clk_en   (bus_clk_en),
        .free_extra   (free_extra),
        .chan_clken   (chan_clken),
        .free_clken   (free_clken),
        .busy         (busy),
        .active_cnt   (active_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total;
    int bad;

    // Reference model: k = ticks seen since the channel's last request cycle,
    // h = hold value captured on the first such tick. A channel stays enabled
    // while k <= h, i.e. for exactly 1 + hold ticks after the last request.
    int                k [NUM_CH];
    int                h [NUM_CH];
    logic [NUM_CH-1:0] bmask;
    logic [NUM_CH-1:0] effq;
    logic              frq;
    logic [NUM_CH-1:0] x_eff;
    logic [NUM_CH-1:0] x_non;
    logic [NUM_CH-1:0] x_clk;
    logic              x_busy;
    logic              x_free_raw;
    logic              x_free;
    int                x_cnt;

    logic [NUM_CH-1:0] smp_clk;
    logic              smp_busy;
    int                smp_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            k[i] = BIG;
            h[i] = 0;
        end
        effq = '0;
        frq  = 1'b0;
    endtask

    task automatic model_eval();
        logic on;
        logic raw;
        on = clk_override | force_halt;
        if (rst) model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst) x_eff[i] = 1'b0;
            else if (i == 0) x_eff[i] = req[i];
            else x_eff[i] = req[i] | (chain_en[i] & effq[i-1]);
            x_non[i] = (k[i] <= h[i]);
            raw = x_eff[i] | x_non[i] | on;
            x_clk[i] = bmask[i] ? (raw & bus_clk_en) : raw;
        end
        x_busy     = |x_non;
        x_free_raw = (|x_eff) | x_busy | (free_extra & ~rst) | on;
        x_free     = x_free_raw | frq;
        x_cnt      = $countones(x_clk);
    endtask

    task automatic model_commit();
        if (!rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (x_eff[i]) begin
                    k[i] = 0;
                end else if ((!bmask[i] || bus_clk_en) && k[i] < BIG) begin
                    if (k[i] == 0) h[i] = int'(hold_cfg[i*HOLD_W +: HOLD_W]);
                    k[i]++;
                end
            end
            effq = x_eff;
            frq  = x_free_raw;
        end
    endtask

    // Called at posedge+1 with inputs set; checks at the falling edge, then advances one cycle.
    task automatic step();
        #4;
        model_eval();
        chk("clken", 32'(chan_clken), 32'(x_clk));
        chk("free_clken", 32'(free_clken), 32'(x_free));
        chk("busy", 32'(busy), 32'(x_busy));
        chk("active_cnt", 32'(active_cnt), 32'(x_cnt));
        smp_clk  = chan_clken;
        smp_busy = busy;
        smp_cnt  = int'(active_cnt);
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        req          = '0;
        chain_en     = '0;
        hold_cfg     = '0;
        clk_override = 1'b0;
        force_halt   = 1'b0;
        bus_clk_en   = 1'b1;
        free_extra   = 1'b0;
    endtask

    task automatic set_hold(input int ch, input int val);
        hold_cfg[ch*HOLD_W +: HOLD_W] = HOLD_W'(val);
    endtask

    task automatic idle(input int n);
        req = '0;
        repeat (n) step();
    endtask

    int         n;
    int         nb;
    int         viol;
    int         falls;
    logic       prev;
    logic [3:0] pat;

    initial begin
        total = 0;
        bad   = 0;
        bmask = BUS_MASK;
        clr();
        model_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        step();
        chk("rst_clken", 32'(smp_clk), 32'h0);
        chk("rst_busy", 32'(smp_busy), 32'h0);
        rst = 1'b0;
        idle(2);

        // One-cycle request, hold 3: five enable cycles, four busy cycles
        set_hold(0, 3);
        req[0] = 1'b1;
        step();
        n  = int'(smp_clk[0]);
        nb = int'(smp_busy);
        req[0] = 1'b0;
        repeat (7) begin
            step();
            n  += int'(smp_clk[0]);
            nb += int'(smp_busy);
        end
        chk("hold3_len", 32'(n), 32'd5);
        chk("hold3_busy", 32'(nb), 32'd4);
        chk("hold3_end", 32'(smp_clk[0]), 32'h0);

        // Chain channel 0 -> 1 with hold 0
        clr();
        idle(2);
        chain_en[1] = 1'b1;
        req[0] = 1'b1;
        step();
        pat = {3'b000, smp_clk[1]};
        req[0] = 1'b0;
        repeat (3) begin
            step();
            pat = {pat[2:0], smp_clk[1]};
        end
        chk("chain_pat", 32'(pat), 32'h6);

        // Bus-qualified channel 2, bus enable every other cycle, hold 2
        clr();
        idle(2);
        set_hold(2, 2);
        req[2] = 1'b1;
        step();
        n    = int'(smp_clk[2]);
        viol = 0;
        req[2] = 1'b0;
        for (int c = 1; c < 12; c++) begin
            bus_clk_en = (c % 2 == 0);
            step();
            n += int'(smp_clk[2]);
            if (smp_clk[2] && !bus_clk_en) viol++;
        end
        chk("bus_len", 32'(n), 32'd4);
        chk("bus_gate", 32'(viol), 32'd0);

        // Request re-asserted on the last HOLD cycle: no gap, hold reloaded
        clr();
        idle(2);
        set_hold(3, 2);
        req[3] = 1'b1;
        step();
        n     = int'(smp_clk[3]);
        prev  = smp_clk[3];
        falls = 0;
        req[3] = 1'b0;
        for (int c = 1; c < 9; c++) begin
            req[3] = (c == 3);
            step();
            n += int'(smp_clk[3]);
            if (prev && !smp_clk[3]) falls++;
            prev = smp_clk[3];
            if (c == 4) chk("reassert_busy", 32'(smp_busy), 32'h1);
        end
        chk("reassert_len", 32'(n), 32'd7);
        chk("reassert_gap", 32'(falls), 32'd1);

        // Override with no requests, then reset in the middle of HOLD
        clr();
        idle(2);
        clk_override = 1'b1;
        step();
        chk("ovr_clken", 32'(smp_clk), 32'hff);
        chk("ovr_cnt", 32'(smp_cnt), 32'(NUM_CH));
        chk("ovr_busy", 32'(smp_busy), 32'h0);
        clk_override = 1'b0;
        set_hold(0, 5);
        req[0] = 1'b1;
        step();
        req[0] = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        chk("rst_mid_clken", 32'(smp_clk[0]), 32'h0);
        chk("rst_mid_busy", 32'(smp_busy), 32'h0);
        rst = 1'b0;
        idle(2);

        // Randomised traffic against the model
        clr();
        for (int c = 0; c < 800; c++) begin
            for (int b = 0; b < NUM_CH; b++) req[b] = ($urandom_range(0, 5) == 0);
            chain_en     = NUM_CH'($urandom);
            bus_clk_en   = ($urandom_range(0, 2) != 0);
            free_extra   = ($urandom_range(0, 3) == 0);
            clk_override = ($urandom_range(0, 24) == 0);
            force_halt   = ($urandom_range(0, 24) == 0);
            rst          = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 5) == 0)
                set_hold(int'($urandom_range(0, NUM_CH - 1)), int'($urandom_range(0, 15)));
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
